// File: rtl/jt08_mix_pkg.sv
// jt08_mix_seq shared types and constants
// Slot order, frame geometry and PCM source encodings
package jt08_mix_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        PCM_SEL_FM = 2'b00,
        PCM_SEL_B  = 2'b01,
        PCM_SEL_A  = 2'b10
    } pcm_sel_e;

    localparam int FRAME_SLOTS = 24;
    localparam int CH_SLOTS    = 6;

    localparam logic [2:0] SLOT_ORDER [CH_SLOTS] = '{
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6
    };

    localparam logic [4:0] LAST_SLOT = {2'd3, 3'd6};

    function automatic logic [2:0] slot_ch(input logic [2:0] pos);
        return SLOT_ORDER[pos];
    endfunction

endpackage

// File: rtl/jt08_mix_if.sv
// jt08_mix_seq ADPCM sample handshake bundle
// Master offers samples, slave acknowledges captures
interface jt08_mix_if;
    import jt08_mix_pkg::*;

    logic    adpcma_valid;
    sample_t adpcma_l;
    sample_t adpcma_r;
    logic    adpcma_ack;
    logic    adpcmb_valid;
    sample_t adpcmb_l;
    sample_t adpcmb_r;
    logic    adpcmb_ack;

    modport master (
        output adpcma_valid, adpcma_l, adpcma_r,
        output adpcmb_valid, adpcmb_l, adpcmb_r,
        input  adpcma_ack, adpcmb_ack
    );

    modport slave (
        input  adpcma_valid, adpcma_l, adpcma_r,
        input  adpcmb_valid, adpcmb_l, adpcmb_r,
        output adpcma_ack, adpcmb_ack
    );

endinterface

// File: rtl/jt08_pcm_port.sv
// jt08_mix_seq per-source sample port
// Capture handshake, frame-aligned active copy, sticky overrun
module jt08_pcm_port
    import jt08_mix_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    frame,
    input  logic    valid,
    input  sample_t smp_l,
    input  sample_t smp_r,
    output logic    ack,
    output sample_t act_l,
    output sample_t act_r,
    output logic    ovf
);

    sample_t hold_l;
    sample_t hold_r;
    logic    cap;
    logic    seen;

    // a sample still offered during its ack cycle is not taken twice
    assign cap = valid & ~ack;

    // latch offered sample and acknowledge it for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack    <= 1'b0;
            hold_l <= '0;
            hold_r <= '0;
        end else begin
            ack <= cap;
            if (cap) begin
                hold_l <= smp_l;
                hold_r <= smp_r;
            end
        end
    end

    // frame boundary publishes the last held sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_l <= '0;
            act_r <= '0;
        end else if (frame) begin
            act_l <= hold_l;
            act_r <= hold_r;
        end
    end

    // a capture on the boundary cycle belongs to the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (frame) seen <= cap;
            else if (cap) seen <= 1'b1;
            if (cap & seen & ~frame) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/jt08_mix_seq.sv
// jt08_mix_seq FM slot sequencer and ADPCM injection scheduler
// Owns all accumulator timing: slot index, frame pulse, PCM slots
module jt08_mix_seq
    import jt08_mix_pkg::*;
#(
    parameter int         PCM_DLY = 2,
    parameter logic [4:0] TRIG_A  = 5'd0,
    parameter logic [4:0] TRIG_B  = 5'd4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic         clk_en,
    jt08_mix_if.slave    adpcm,
    output logic [2:0]   cur_ch,
    output logic [1:0]   cur_op,
    output logic         zero,
    output pcm_sel_e     pcm_sel,
    output logic         acc_clk_en,
    output sample_t      pcm_l,
    output sample_t      pcm_r,
    output logic [1:0]   ovf
);

    logic [2:0]         pos;
    logic               adv;
    logic               frame;
    logic               trig_a;
    logic               trig_b;
    logic [PCM_DLY-1:0] pipe_a;
    logic [PCM_DLY-1:0] pipe_b;
    logic               pend_a;
    logic               pend_b;
    logic               want_a;
    logic               want_b;
    logic               inj;
    logic               inj_a;
    logic               inj_b;
    sample_t            act_al;
    sample_t            act_ar;
    sample_t            act_bl;
    sample_t            act_br;
    logic               ovf_a;
    logic               ovf_b;

    assign adv    = cen & clk_en;
    assign cur_ch = slot_ch(pos);
    assign zero   = ({cur_op, cur_ch} == LAST_SLOT);
    assign frame  = adv & zero;
    assign trig_a = adv & ({cur_op, cur_ch} == TRIG_A);
    assign trig_b = adv & ({cur_op, cur_ch} == TRIG_B);

    // the pipe tail counts as pending on the cen cycle it arrives
    assign want_a = pend_a | pipe_a[PCM_DLY-1];
    assign want_b = pend_b | pipe_b[PCM_DLY-1];
    assign inj    = cen & ~clk_en;
    assign inj_a  = inj & want_a;
    assign inj_b  = inj & want_b & ~want_a;
    assign ovf    = {ovf_a, ovf_b};

    // slot position walks the channel table, operator bumps on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    <= 3'd0;
            cur_op <= 2'd0;
        end else if (adv) begin
            if (pos == 3'(CH_SLOTS - 1)) begin
                pos    <= 3'd0;
                cur_op <= cur_op + 2'd1;
            end else begin
                pos <= pos + 3'd1;
            end
        end
    end

    // trigger delay pipes and pending flags advance on cen only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_a <= '0;
            pipe_b <= '0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else if (cen) begin
            pipe_a <= PCM_DLY'({pipe_a, trig_a});
            pipe_b <= PCM_DLY'({pipe_b, trig_b});
            pend_a <= want_a & ~inj_a;
            pend_b <= want_b & ~inj_b;
        end
    end

    // accumulator controls: one-clk PCM slot or pass-through FM enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_sel    <= PCM_SEL_FM;
            acc_clk_en <= 1'b0;
            pcm_l      <= '0;
            pcm_r      <= '0;
        end else begin
            unique case (1'b1)
                inj_a: begin
                    pcm_sel    <= PCM_SEL_A;
                    acc_clk_en <= 1'b1;
                    pcm_l      <= act_al;
                    pcm_r      <= act_ar;
                end
                inj_b: begin
                    pcm_sel    <= PCM_SEL_B;
                    acc_clk_en <= 1'b1;
                    pcm_l      <= act_bl;
                    pcm_r      <= act_br;
                end
                default: begin
                    pcm_sel    <= PCM_SEL_FM;
                    acc_clk_en <= adv;
                end
            endcase
        end
    end

    jt08_pcm_port u_port_a (
        .clk   (clk),
        .rst_n (rst_n),
        .frame (frame),
        .valid (adpcm.adpcma_valid),
        .smp_l (adpcm.adpcma_l),
        .smp_r (adpcm.adpcma_r),
        .ack   (adpcm.adpcma_ack),
        .act_l (act_al),
        .act_r (act_ar),
        .ovf   (ovf_a)
    );

    jt08_pcm_port u_port_b (
        .clk   (clk),
        .rst_n (rst_n),
        .frame (frame),
        .valid (adpcm.adpcmb_valid),
        .smp_l (adpcm.adpcmb_l),
        .smp_r (adpcm.adpcmb_r),
        .ack   (adpcm.adpcmb_ack),
        .act_l (act_bl),
        .act_r (act_br),
        .ovf   (ovf_b)
    );

endmodule

// File: tb/tb_jt08_mix_seq.sv
// jt08_mix_seq bench: slot-level reference model plus directed scenarios
// Model counts slots and cen cycles; compare runs every negedge
module tb_jt08_mix_seq;
    import jt08_mix_pkg::*;

    localparam int         PCM_DLY = 2;
    localparam logic [4:0] TRIG_A  = 5'd0;
    localparam logic [4:0] TRIG_B  = 5'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen = 1'b0;
    logic        clk_en = 1'b0;
    logic [2:0]  cur_ch;
    logic [1:0]  cur_op;
    logic        zero;
    logic [1:0]  pcm_sel;
    logic        acc_clk_en;
    logic [15:0] pcm_l;
    logic [15:0] pcm_r;
    logic [1:0]  ovf;

    jt08_mix_if bus ();

    jt08_mix_seq #(
        .PCM_DLY (PCM_DLY),
        .TRIG_A  (TRIG_A),
        .TRIG_B  (TRIG_B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .clk_en     (clk_en),
        .adpcm      (bus),
        .cur_ch     (cur_ch),
        .cur_op     (cur_op),
        .zero       (zero),
        .pcm_sel    (pcm_sel),
        .acc_clk_en (acc_clk_en),
        .pcm_l      (pcm_l),
        .pcm_r      (pcm_r),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;
    int mode = 0;
    int burst = 0;
    int ph = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp,
                     $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    int          chtab [6] = '{0, 1, 2, 4, 5, 6};
    int          m_slot;
    int          m_cidx;
    int          due   [2];
    bit          pend  [2];
    logic [15:0] h_l   [2];
    logic [15:0] h_r   [2];
    logic [15:0] a_l   [2];
    logic [15:0] a_r   [2];
    bit          mack  [2];
    bit          seen  [2];
    bit          movf  [2];
    logic [1:0]  e_sel;
    bit          e_acc;
    logic [15:0] e_l;
    logic [15:0] e_r;

    function automatic logic [4:0] code_of(input int s);
        logic [1:0] op;
        logic [2:0] ch;
        op = 2'(s / 6);
        ch = 3'(chtab[s % 6]);
        return {op, ch};
    endfunction

    task automatic m_reset();
        m_slot = 0;
        m_cidx = 0;
        e_sel = 2'b00;
        e_acc = 0;
        e_l = '0;
        e_r = '0;
        for (int k = 0; k < 2; k++) begin
            due[k] = -1;
            pend[k] = 0;
            h_l[k] = '0;
            h_r[k] = '0;
            a_l[k] = '0;
            a_r[k] = '0;
            mack[k] = 0;
            seen[k] = 0;
            movf[k] = 0;
        end
    endtask

    task automatic m_step();
        bit adv;
        bit frame;
        bit cap;
        bit v [2];
        logic [15:0] dl [2];
        logic [15:0] dr [2];
        v[0] = bus.adpcma_valid;
        v[1] = bus.adpcmb_valid;
        dl[0] = bus.adpcma_l;
        dl[1] = bus.adpcmb_l;
        dr[0] = bus.adpcma_r;
        dr[1] = bus.adpcmb_r;
        adv = cen && clk_en;
        frame = adv && (m_slot == FRAME_SLOTS - 1);
        if (cen) begin
            for (int k = 0; k < 2; k++)
                if (due[k] == m_cidx) pend[k] = 1;
            if (!clk_en && pend[0]) begin
                e_sel = 2'b10;
                e_acc = 1;
                e_l = a_l[0];
                e_r = a_r[0];
                pend[0] = 0;
            end else if (!clk_en && pend[1]) begin
                e_sel = 2'b01;
                e_acc = 1;
                e_l = a_l[1];
                e_r = a_r[1];
                pend[1] = 0;
            end else begin
                e_sel = 2'b00;
                e_acc = adv;
            end
            if (adv && code_of(m_slot) == TRIG_A) due[0] = m_cidx + PCM_DLY;
            if (adv && code_of(m_slot) == TRIG_B) due[1] = m_cidx + PCM_DLY;
            m_cidx++;
        end else begin
            e_sel = 2'b00;
            e_acc = 0;
        end
        if (adv) m_slot = (m_slot + 1) % FRAME_SLOTS;
        for (int k = 0; k < 2; k++) begin
            cap = v[k] && !mack[k];
            if (frame) begin
                a_l[k] = h_l[k];
                a_r[k] = h_r[k];
            end
            if (cap) begin
                if (seen[k] && !frame) movf[k] = 1;
                h_l[k] = dl[k];
                h_r[k] = dr[k];
            end
            seen[k] = frame ? cap : (seen[k] || cap);
            mack[k] = cap;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("cur_ch", 32'(cur_ch), 32'(chtab[m_slot % 6]));
                chk("cur_op", 32'(cur_op), 32'(m_slot / 6));
                chk("zero", 32'(zero), 32'(m_slot == FRAME_SLOTS - 1));
                chk("pcm_sel", 32'(pcm_sel), 32'(e_sel));
                chk("acc_clk_en", 32'(acc_clk_en), 32'(e_acc));
                chk("pcm_l", 32'(pcm_l), 32'(e_l));
                chk("pcm_r", 32'(pcm_r), 32'(e_r));
                chk("ovf", 32'(ovf), 32'({movf[0], movf[1]}));
                chk("ack_a", 32'(bus.adpcma_ack), 32'(mack[0]));
                chk("ack_b", 32'(bus.adpcmb_ack), 32'(mack[1]));
            end
        end
    end

    // ---------------- cen / clk_en generator ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            ph++;
            if (burst > 0) begin
                cen = 1;
                clk_en = 1;
                burst--;
            end else begin
                case (mode)
                    1: begin cen = 1; clk_en = (ph % 2 == 0); end
                    3: begin cen = (ph % 2 == 0); clk_en = (ph % 4 == 0); end
                    default: begin cen = 1; clk_en = (ph % 4 == 0); end
                endcase
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_boundary();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (zero && cen && clk_en) return;
        end
        timeout("wait_boundary");
    endtask

    task automatic wait_sel(input logic [1:0] s);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pcm_sel == s) return;
        end
        timeout("wait_sel");
    endtask

    task automatic capture(input int k, input logic [15:0] l,
                           input logic [15:0] r);
        @(posedge clk);
        #2;
        if (k == 0) begin
            bus.adpcma_valid = 1; bus.adpcma_l = l; bus.adpcma_r = r;
        end else begin
            bus.adpcmb_valid = 1; bus.adpcmb_l = l; bus.adpcmb_r = r;
        end
        @(posedge clk);
        #2;
        bus.adpcma_valid = 0;
        bus.adpcmb_valid = 0;
        @(negedge clk);
        chk("ack_high", 32'(k == 0 ? bus.adpcma_ack : bus.adpcmb_ack), 1);
        @(negedge clk);
        chk("ack_one_cycle", 32'(k == 0 ? bus.adpcma_ack : bus.adpcmb_ack),
            0);
    endtask

    initial begin
        int n;
        int t0;
        int t1;
        int na;
        int nb;
        int cnt;
        bit hit;
        bus.adpcma_valid = 0;
        bus.adpcma_l = '0;
        bus.adpcma_r = '0;
        bus.adpcmb_valid = 0;
        bus.adpcmb_l = '0;
        bus.adpcmb_r = '0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_cur_ch", 32'(cur_ch), 0);
        chk("rst_cur_op", 32'(cur_op), 0);
        chk("rst_zero", 32'(zero), 0);
        chk("rst_pcm_sel", 32'(pcm_sel), 0);
        chk("rst_acc", 32'(acc_clk_en), 0);
        chk("rst_pcm_l", 32'(pcm_l), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_ack_a", 32'(bus.adpcma_ack), 0);
        cmp_on = 1;
        @(posedge clk);
        #2;
        rst_n = 1;
        @(negedge clk);
        chk("first_slot", 32'({cur_op, cur_ch}), 0);

        // 24 slot advances per frame
        wait_boundary();
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cen && clk_en) n++;
            if (zero && cen && clk_en) break;
        end
        chk("advs_per_frame", 32'(n), 24);

        // ADPCM-A capture and injection in the following frame
        capture(0, 16'h1234, 16'hEDCC);
        wait_boundary();
        wait_sel(2'b10);
        chk("a_inj_l", 32'(pcm_l), 32'h1234);
        chk("a_inj_r", 32'(pcm_r), 32'hEDCC);
        chk("a_inj_acc", 32'(acc_clk_en), 1);
        @(negedge clk);
        chk("a_inj_one_clk", 32'(pcm_sel), 0);

        // clk_en high on the due cen cycle defers A by one cen
        mode = 1;
        wait_boundary();
        wait_boundary();
        t0 = -1;
        t1 = -1;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (t0 < 0 && cur_op == 2'd0 && cur_ch == 3'd1) t0 = i;
            if (pcm_sel == 2'b10) begin
                cnt++;
                t1 = i;
            end
            if (zero && cen && clk_en) break;
        end
        chk("a_inj_per_frame", 32'(cnt), 1);
        chk("a_deferred_delay", 32'(t1 - t0), 3);

        // long clk_en burst leaves A and B pending together
        mode = 0;
        wait_boundary();
        burst = 8;
        na = -1;
        nb = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pcm_sel == 2'b10 && na < 0) na = i;
            if (pcm_sel == 2'b01 && nb < 0) nb = i;
        end
        chk("collision_a_seen", 32'(na >= 0), 1);
        hit = (nb - na >= 1) && (nb - na <= 2);
        chk("collision_b_after_a", 32'(hit), 1);

        // two B captures in one frame: overrun, newest wins
        wait_boundary();
        capture(1, 16'h0100, 16'hFF00);
        chk("ovf_single", 32'(ovf), 0);
        capture(1, 16'h0200, 16'hFE00);
        chk("ovf_set", 32'(ovf), 32'h1);
        wait_boundary();
        wait_sel(2'b01);
        chk("b_newest_l", 32'(pcm_l), 32'h0200);
        chk("b_newest_r", 32'(pcm_r), 32'hFE00);
        chk("ovf_sticky", 32'(ovf), 32'h1);
        wait_boundary();
        wait_sel(2'b01);
        chk("b_repeat_l", 32'(pcm_l), 32'h0200);
        chk("ovf_sticky2", 32'(ovf), 32'h1);

        // sparse cen
        mode = 3;
        wait_boundary();
        wait_boundary();

        // reset mid-frame right after the A trigger
        mode = 0;
        hit = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cur_op == 2'd0 && cur_ch == 3'd1) begin
                hit = 1;
                break;
            end
        end
        if (!hit) timeout("wait_a_trigger");
        #1;
        rst_n = 0;
        #1;
        chk("mid_rst_ch", 32'(cur_ch), 0);
        chk("mid_rst_op", 32'(cur_op), 0);
        chk("mid_rst_sel", 32'(pcm_sel), 0);
        chk("mid_rst_acc", 32'(acc_clk_en), 0);
        chk("mid_rst_pcm", 32'({pcm_l, pcm_r}), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_slot", 32'({cur_op, cur_ch}), 0);
        wait_sel(2'b10);
        chk("post_rst_no_stale", 32'(pcm_l), 0);
        wait_boundary();

        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule

// File: doc/jt08_mix_seq.md
Name: jt08_mix_seq

Overview:
- Slot sequencer and ADPCM injection scheduler for the YM2608 stereo accumulator.
- Generates the FM slot index (cur_ch/cur_op) and the frame `zero` pulse.
- Schedules one ADPCM-A and one ADPCM-B accumulation slot per frame and owns the valid/ack capture of ADPCM samples.
- Drives the accumulator's clock enable, input select and PCM data, so the accumulator itself holds no timing state.

Parameters:
- PCM_DLY, 2, cen cycles from the trigger slot's clk_en to its PCM injection (legal range 1..3).
- TRIG_A, 5'd0, {op,ch} slot that triggers ADPCM-A injection.
- TRIG_B, 5'd4, {op,ch} slot that triggers ADPCM-B injection.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  master clock enable
- clk_en  in  1  FM slot advance enable; qualified by cen
- adpcma_valid  in  1  ADPCM-A sample offered
- adpcma_l, adpcma_r  in  16 each  signed ADPCM-A sample
- adpcma_ack  out  1  ADPCM-A sample captured
- adpcmb_valid  in  1  ADPCM-B sample offered
- adpcmb_l, adpcmb_r  in  16 each  signed ADPCM-B sample
- adpcmb_ack  out  1  ADPCM-B sample captured
- cur_ch  out  3  FM channel: 0,1,2,4,5,6 only
- cur_op  out  2  FM operator
- zero  out  1  high for the whole last slot of the frame
- pcm_sel  out  2  2'b10 = ADPCM-A, 2'b01 = ADPCM-B, 2'b00 = FM
- acc_clk_en  out  1  accumulator clock enable
- pcm_l, pcm_r  out  16 each  active PCM sample for the selected source
- ovf  out  2  sticky overrun flags {A,B}

Behaviour:
- Reset (async, rst_n low): cur_op=0, cur_ch=0, zero=0, pcm_sel=0, acc_clk_en=0, both acks=0, pcm_l/r=0, all holding/active registers=0, ovf=0, delay pipes and pending flags cleared. Reset mid-frame abandons the frame; the sequence restarts at slot {0,0}.
- Slot counter:
  - Advances only on cen & clk_en.
  - Channel order 0,1,2,4,5,6; after channel 6, cur_op increments (3 wraps to 0). 24 slots per frame.
  - Channels 3 and 7 are never produced.
- zero: combinational from the registered slot; high while {cur_op,cur_ch} = {3,6}.
- Frame boundary is cen & clk_en while zero=1. On it:
  - each holding register copies to its active register;
  - ovf is not cleared.
- Injection trigger: on cen & clk_en at slot TRIG_A (TRIG_B), a 1 enters that source's PCM_DLY-stage delay pipe, which shifts on cen only.
- Injection:
  - When a pipe's output is 1, that source goes pending.
  - A pending source injects on the first cen cycle with clk_en=0: pcm_sel set, acc_clk_en=1, pcm_l/r = that source's active sample, for exactly one clk cycle. Pending then clears.
  - A pending source is held across cen cycles where clk_en=1.
  - If A and B are pending together, A injects first and B on the next eligible cycle.
- Outside injection: acc_clk_en = clk_en, pcm_sel=0, pcm_l/r hold their last value.
- All of pcm_sel, acc_clk_en and pcm_l/r are registered outputs with one clk latency from the deciding cen cycle.
- Capture handshake, per source, on clk and independent of cen:
  - valid & ~ack: latch l/r into the holding register; ack=1 next cycle for exactly one cycle.
  - Valid still high while ack=1 is not recaptured. The source must drop valid, or present new data, after ack.
- Overrun: a second capture of the same source within one frame (between two frame boundaries) sets that source's ovf bit. The newest sample wins.
- No new valid during a frame: the previous active sample repeats.
- Arithmetic: no scaling or saturation here; samples pass unmodified. The accumulator applies the weighting.

Decomposition:
- Shared package jt08_mix_pkg holds:
  - PCM_SEL_FM/A/B encodings;
  - slot-order table {0,1,2,4,5,6};
  - FRAME_SLOTS=24;
  - last-slot constant {3,6}.
- Sub-module jt08_pcm_port, instantiated twice (A, B): valid/ack capture, holding→active transfer on frame boundary, sticky overrun.

Test Plan:
- Reset then cen=1 and clk_en every 4th clk, no PCM -> slots cycle ch 0,1,2,4,5,6 per op; zero high only at {3,6}; 24 clk_en per frame; pcm_sel stays 00.
- adpcma_valid with l=16'h1234, r=16'hEDCC -> ack one cycle later for one cycle. After the next frame boundary, the first A injection shows pcm_sel=10, acc_clk_en=1, pcm_l=16'h1234 for one clk.
- PCM_DLY=2 with clk_en forced high on the cen cycle where A would inject -> injection deferred to the next cen with clk_en=0. Exactly one A injection per frame.
- Drive TRIG_A=TRIG_B to force a collision -> A injects first, B on the next eligible cycle; no lost injection.
- Two B captures (16'h0100, then 16'h0200) in one frame -> ovf=01 and stays set; next frame injects 16'h0200. No capture the following frame -> 16'h0200 repeats.
- Assert rst_n low mid-frame with A pending -> all outputs go 0 immediately. After release, the first slot is {0,0} and no stale injection occurs.
